// File: rtl/hls_mem_responder_pkg.sv
// Shared definitions for the HLS command-FIFO memory responder: FSM state
// encoding, beat-counter width and the transfer-size to beat-count mapping.
package hls_mem_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_ISSUE,
      ST_RD_CAPTURE,
      ST_RD_PUSH
   } state_t;

   // Wide enough for a 32-beat burst (size 7 on a 32-bit word)
   localparam int BEAT_W = 6;

   // size is log2 of the transfer length in bytes; anything up to one word
   // is a single beat, larger transfers are a power-of-two number of words.
   function automatic logic [BEAT_W-1:0] size_to_beats(input logic [2:0] size,
                                                       input int word_shift);
      int excess;
      excess = int'(size) - word_shift;
      if (excess <= 0) return BEAT_W'(1);
      return BEAT_W'(1) << excess;
   endfunction

endpackage

// File: rtl/hls_mem_responder.sv
// Consumes one command from the seven CPU-command FIFOs, performs it on a
// single-port word-addressed BRAM and returns read data beats through the
// paired data/last response FIFOs. Writes are single-beat and byte-masked;
// reads may burst for cache-line refills.
module hls_mem_responder
   import hls_mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH  = 12
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic [DATA_ADDR_WIDTH-1:0] cmd_address_dout,
   input  logic                       cmd_address_empty_n,
   output logic                       cmd_address_read,
   input  logic [DATA_WIDTH-1:0]      cmd_data_dout,
   input  logic                       cmd_data_empty_n,
   output logic                       cmd_data_read,
   input  logic [DATA_WIDTH/8-1:0]    cmd_mask_dout,
   input  logic                       cmd_mask_empty_n,
   output logic                       cmd_mask_read,
   input  logic                       cmd_write_dout,
   input  logic                       cmd_write_empty_n,
   output logic                       cmd_write_read,
   input  logic                       cmd_uncached_dout,
   input  logic                       cmd_uncached_empty_n,
   output logic                       cmd_uncached_read,
   input  logic [2:0]                 cmd_size_dout,
   input  logic                       cmd_size_empty_n,
   output logic                       cmd_size_read,
   input  logic                       cmd_last_dout,
   input  logic                       cmd_last_empty_n,
   output logic                       cmd_last_read,

   output logic [DATA_WIDTH-1:0]      rsp_data_din,
   input  logic                       rsp_data_full_n,
   output logic                       rsp_data_write,
   output logic                       rsp_last_din,
   input  logic                       rsp_last_full_n,
   output logic                       rsp_last_write,

   output logic                       mem_en,
   output logic [DATA_WIDTH/8-1:0]    mem_we,
   output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   input  logic [DATA_WIDTH-1:0]      mem_rdata
);

   localparam int MASK_W     = DATA_WIDTH / 8;
   localparam int WORD_SHIFT = $clog2(MASK_W);

   // Packed command layout: {data, mask, write, uncached, size, last}
   localparam int LAST_B   = 0;
   localparam int SIZE_LSB = 1;
   localparam int UNC_B    = 4;
   localparam int WR_B     = 5;
   localparam int MASK_LSB = 6;
   localparam int DATA_LSB = MASK_LSB + MASK_W;
   localparam int CMD_W    = DATA_LSB + DATA_WIDTH;

   state_t                    state;
   logic [CMD_W-1:0]          cmd_q;
   logic [MEM_ADDR_WIDTH-1:0] base_addr;
   logic [BEAT_W-1:0]         beat_cnt;
   logic [BEAT_W-1:0]         beat_total;
   logic                      all_ready;
   logic                      pop;
   logic                      push;
   logic                      unused_bits;

   // All seven FIFOs must present an entry so their heads stay aligned
   assign all_ready = cmd_address_empty_n & cmd_data_empty_n & cmd_mask_empty_n &
                      cmd_write_empty_n & cmd_uncached_empty_n & cmd_size_empty_n &
                      cmd_last_empty_n;
   assign pop  = !rst && (state == ST_IDLE) && all_ready;
   // Push only when both response FIFOs can take the beat, so they never drift apart
   assign push = !rst && (state == ST_RD_PUSH) && rsp_data_full_n && rsp_last_full_n;

   assign cmd_address_read  = pop;
   assign cmd_data_read     = pop;
   assign cmd_mask_read     = pop;
   assign cmd_write_read    = pop;
   assign cmd_uncached_read = pop;
   assign cmd_size_read     = pop;
   assign cmd_last_read     = pop;

   assign rsp_data_write = push;
   assign rsp_last_write = push;

   // uncached/last are carried for completeness only; low and high address bits are don't-care
   assign unused_bits = ^{cmd_q[UNC_B], cmd_q[LAST_B], cmd_q[WR_B],
                          cmd_q[SIZE_LSB +: 3], cmd_address_dout};

   // Latch the popped command and its BRAM word address
   always_ff @(posedge clk) begin
      if (pop) begin
         cmd_q     <= {cmd_data_dout, cmd_mask_dout, cmd_write_dout, cmd_uncached_dout,
                       cmd_size_dout, cmd_last_dout};
         base_addr <= cmd_address_dout[MEM_ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];
      end
   end

   // Command sequencer: one write cycle, or issue/capture/push per read beat
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         beat_cnt     <= '0;
         beat_total   <= '0;
         rsp_data_din <= '0;
         rsp_last_din <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  beat_cnt <= '0;
                  if (cmd_write_dout) begin
                     beat_total <= BEAT_W'(1);
                     state      <= ST_WRITE;
                  end else begin
                     beat_total <= size_to_beats(cmd_size_dout, WORD_SHIFT);
                     state      <= ST_RD_ISSUE;
                  end
               end
            end
            ST_WRITE: begin
               state <= ST_IDLE;
            end
            ST_RD_ISSUE: begin
               state <= ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
               rsp_data_din <= mem_rdata;
               rsp_last_din <= (beat_cnt == beat_total - BEAT_W'(1));
               state        <= ST_RD_PUSH;
            end
            ST_RD_PUSH: begin
               if (push) begin
                  if (rsp_last_din) begin
                     state <= ST_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                     state    <= ST_RD_ISSUE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // BRAM port decode; burst addresses wrap naturally at the memory size
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         case (state)
            ST_WRITE: begin
               mem_en    = 1'b1;
               mem_we    = cmd_q[MASK_LSB +: MASK_W];
               mem_wdata = cmd_q[DATA_LSB +: DATA_WIDTH];
               mem_addr  = base_addr;
            end
            ST_RD_ISSUE: begin
               mem_en   = 1'b1;
               mem_addr = base_addr + MEM_ADDR_WIDTH'(beat_cnt);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hls_mem_responder.sv
// Bench for hls_mem_responder: queue-based command FIFOs, a BRAM model, and
// a word-array reference memory that predicts every response beat.
module tb_hls_mem_responder;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        wr;
    logic        unc;
    logic [2:0]  size;
    logic        last;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk, rst;
  logic [31:0] cmd_address_dout, cmd_data_dout;
  logic [3:0]  cmd_mask_dout;
  logic        cmd_write_dout, cmd_uncached_dout, cmd_last_dout;
  logic [2:0]  cmd_size_dout;
  logic        cmd_address_empty_n, cmd_data_empty_n, cmd_mask_empty_n, cmd_write_empty_n;
  logic        cmd_uncached_empty_n, cmd_size_empty_n, cmd_last_empty_n;
  logic        cmd_address_read, cmd_data_read, cmd_mask_read, cmd_write_read;
  logic        cmd_uncached_read, cmd_size_read, cmd_last_read;
  logic [31:0] rsp_data_din;
  logic        rsp_last_din, rsp_data_full_n, rsp_last_full_n, rsp_data_write, rsp_last_write;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] bram [4096];
  logic        init_mem;

  cmd_t        cmd_fifo [$];
  beat_t       exp_q [$];
  int          pop_cyc_q [$];
  int          push_cyc_q [$];
  logic [31:0] ref_mem [4096];
  logic [6:0]  hold_empty;
  logic        pop_pend;
  int          cycle, n_pop, rsp_count, last_push;
  int          n_assert, n_fail;

  hls_mem_responder dut (
    .clk(clk), .rst(rst),
    .cmd_address_dout(cmd_address_dout), .cmd_address_empty_n(cmd_address_empty_n),
    .cmd_address_read(cmd_address_read),
    .cmd_data_dout(cmd_data_dout), .cmd_data_empty_n(cmd_data_empty_n), .cmd_data_read(cmd_data_read),
    .cmd_mask_dout(cmd_mask_dout), .cmd_mask_empty_n(cmd_mask_empty_n), .cmd_mask_read(cmd_mask_read),
    .cmd_write_dout(cmd_write_dout), .cmd_write_empty_n(cmd_write_empty_n),
    .cmd_write_read(cmd_write_read),
    .cmd_uncached_dout(cmd_uncached_dout), .cmd_uncached_empty_n(cmd_uncached_empty_n),
    .cmd_uncached_read(cmd_uncached_read),
    .cmd_size_dout(cmd_size_dout), .cmd_size_empty_n(cmd_size_empty_n), .cmd_size_read(cmd_size_read),
    .cmd_last_dout(cmd_last_dout), .cmd_last_empty_n(cmd_last_empty_n), .cmd_last_read(cmd_last_read),
    .rsp_data_din(rsp_data_din), .rsp_data_full_n(rsp_data_full_n), .rsp_data_write(rsp_data_write),
    .rsp_last_din(rsp_last_din), .rsp_last_full_n(rsp_last_full_n), .rsp_last_write(rsp_last_write),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: byte-enabled write, registered read one cycle after enable
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) bram[i] <= 32'h0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= bram[mem_addr];
    end
  end

  // Command FIFO model and response scoreboard, sampled between clock edges
  always @(negedge clk) begin
    cmd_t h;
    int   qs;
    beat_t b;
    cycle++;
    if (pop_pend) begin
      void'(cmd_fifo.pop_front());
      pop_pend = 1'b0;
    end
    if (cmd_fifo.size() > 0) begin
      h = cmd_fifo[0];
      cmd_address_dout  = h.addr;
      cmd_data_dout     = h.data;
      cmd_mask_dout     = h.mask;
      cmd_write_dout    = h.wr;
      cmd_uncached_dout = h.unc;
      cmd_size_dout     = h.size;
      cmd_last_dout     = h.last;
    end
    cmd_address_empty_n  = (cmd_fifo.size() > 0) && !hold_empty[0];
    cmd_data_empty_n     = (cmd_fifo.size() > 0) && !hold_empty[1];
    cmd_mask_empty_n     = (cmd_fifo.size() > 0) && !hold_empty[2];
    cmd_write_empty_n    = (cmd_fifo.size() > 0) && !hold_empty[3];
    cmd_uncached_empty_n = (cmd_fifo.size() > 0) && !hold_empty[4];
    cmd_size_empty_n     = (cmd_fifo.size() > 0) && !hold_empty[5];
    cmd_last_empty_n     = (cmd_fifo.size() > 0) && !hold_empty[6];
    #1;
    if (!rst) begin
      chk("read_group", {cmd_data_read, cmd_mask_read, cmd_write_read, cmd_uncached_read,
                         cmd_size_read, cmd_last_read}, {6{cmd_address_read}});
      if (cmd_address_read) begin
        chk("pop_needs_all", cmd_address_empty_n & cmd_data_empty_n & cmd_mask_empty_n &
            cmd_write_empty_n & cmd_uncached_empty_n & cmd_size_empty_n & cmd_last_empty_n, 1'b1);
        pop_pend = 1'b1;
        n_pop++;
        pop_cyc_q.push_back(cycle);
      end
      chk("write_pair", rsp_data_write, rsp_last_write);
      if (rsp_data_write) begin
        chk("write_full_n", rsp_data_full_n & rsp_last_full_n, 1'b1);
        qs = exp_q.size();
        chk("rsp_expected", qs > 0, 1'b1);
        if (qs > 0) begin
          b = exp_q.pop_front();
          chk("rsp_data", rsp_data_din, b.data);
          chk("rsp_last", rsp_last_din, b.last);
        end
        rsp_count++;
        push_cyc_q.push_back(cycle);
        last_push = cycle;
      end
    end
  end

  // Enqueue a command and advance the reference memory / expected beats
  task automatic push_cmd(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input logic wr, input logic [2:0] size);
    cmd_t c;
    int   w, n;
    c = '{addr: addr, data: data, mask: mask, wr: wr, unc: 1'($urandom), size: size,
          last: 1'($urandom)};
    cmd_fifo.push_back(c);
    w = int'(addr[13:2]);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
    end else begin
      n = (size <= 3'd2) ? 1 : (1 << (int'(size) - 2));
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: ref_mem[(w + i) % 4096], last: (i == n - 1)});
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t;
    t = 0;
    while ((cmd_fifo.size() > 0 || exp_q.size() > 0 || pop_pend) && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk(tag, t < budget, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int t;
    t = 0;
    while (rsp_count < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("beat_wait", t < budget, 1'b1);
  endtask

  initial begin
    int p0, start, sent, d;
    n_assert = 0; n_fail = 0; cycle = 0; n_pop = 0; rsp_count = 0; last_push = 0;
    pop_pend = 1'b0; hold_empty = 7'h0; init_mem = 1'b1;
    rst = 1'b1; rsp_data_full_n = 1'b1; rsp_last_full_n = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    #2;
    chk("reset_read", cmd_address_read, 1'b0);
    chk("reset_write", {rsp_data_write, rsp_last_write}, 2'b00);
    chk("reset_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 49'h0);
    chk("reset_din", {rsp_data_din, rsp_last_din}, 33'h0);
    @(negedge clk);
    rst = 1'b0;

    // Write then single-beat read, with pop-to-pop and pop-to-push latency
    pop_cyc_q.delete();
    push_cmd(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 3'd2);
    push_cmd(32'h10, 32'h0, 4'h0, 1'b0, 3'd2);
    wait_done("t1_done", 100);
    chk("t1_pops", pop_cyc_q.size(), 2);
    if (pop_cyc_q.size() == 2) begin
      chk("t1_w_to_r", pop_cyc_q[1] - pop_cyc_q[0], 2);
      chk("t1_latency", last_push - pop_cyc_q[1], 3);
    end

    // Byte-masked write merges into existing word
    push_cmd(32'h40, 32'h11223344, 4'hF, 1'b1, 3'd2);
    push_cmd(32'h40, 32'hAABBCCDD, 4'h5, 1'b1, 3'd0);
    push_cmd(32'h40, 32'h0, 4'h0, 1'b0, 3'd1);
    wait_done("t2_done", 100);
    chk("t2_model", ref_mem[16], 32'h11BB33DD);

    // Cache-line refill, 3 cycles per beat, next command right after last beat
    for (int i = 0; i < 8; i++) push_cmd(32'h20 + 32'(4 * i), 32'(i), 4'hF, 1'b1, 3'd2);
    wait_done("t3_preload", 200);
    pop_cyc_q.delete(); push_cyc_q.delete();
    push_cmd(32'h20, 32'h0, 4'h0, 1'b0, 3'd5);
    push_cmd(32'h80, 32'h5A5A5A5A, 4'hF, 1'b1, 3'd2);
    wait_done("t3_done", 200);
    chk("t3_beats", push_cyc_q.size(), 8);
    for (int i = 1; i < push_cyc_q.size(); i++) chk("t3_spacing", push_cyc_q[i] - push_cyc_q[i-1], 3);
    if (pop_cyc_q.size() == 2) chk("t3_next_pop", pop_cyc_q[1] - push_cyc_q[push_cyc_q.size()-1], 1);

    // Backpressure on beat 3 of a refill
    start = rsp_count;
    push_cmd(32'h20, 32'h0, 4'h0, 1'b0, 3'd5);
    wait_beats(start + 3, 100);
    rsp_data_full_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      chk("t4_no_write", {rsp_data_write, rsp_last_write}, 2'b00);
      if (i >= 3 && exp_q.size() > 0) begin
        chk("t4_hold_data", rsp_data_din, exp_q[0].data);
        chk("t4_hold_last", rsp_last_din, exp_q[0].last);
      end
    end
    @(negedge clk);
    rsp_data_full_n = 1'b1;
    wait_done("t4_done", 200);
    chk("t4_total", rsp_count - start, 8);

    // One command FIFO empty blocks the pop entirely
    hold_empty = 7'b0000100;
    p0 = n_pop;
    push_cmd(32'h44, 32'hCAFEF00D, 4'hF, 1'b1, 3'd2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      chk("t5_no_read", cmd_address_read, 1'b0);
    end
    @(negedge clk);
    hold_empty = 7'h0;
    push_cmd(32'h44, 32'h0, 4'h0, 1'b0, 3'd2);
    wait_done("t5_done", 100);
    chk("t5_pops", n_pop - p0, 2);

    // Reset during beat 4 of an 8-beat read
    start = rsp_count;
    push_cmd(32'h20, 32'h0, 4'h0, 1'b0, 3'd5);
    wait_beats(start + 4, 100);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("t6_idle_outputs", {cmd_address_read, rsp_data_write, mem_en, mem_we, mem_addr,
                            mem_wdata, rsp_data_din, rsp_last_din}, 84'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      chk("t6_no_write", rsp_data_write, 1'b0);
    end
    chk("t6_dropped", rsp_count - start, 4);
    @(negedge clk);
    push_cmd(32'h3FF8, 32'h76543210, 4'hF, 1'b1, 3'd2);
    push_cmd(32'hFFFF_C004, 32'h01020304, 4'hF, 1'b1, 3'd2);
    push_cmd(32'h3FF8, 32'h0, 4'h0, 1'b0, 3'd4);
    wait_done("t6_after", 200);

    // Random traffic with independent response backpressure
    sent = 0;
    for (int c = 0; c < 6000 && sent < 60; c++) begin
      @(negedge clk);
      rsp_data_full_n = ($urandom_range(0, 3) != 0);
      rsp_last_full_n = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && cmd_fifo.size() < 2) begin
        d = $urandom_range(0, 63);
        push_cmd(($urandom & 32'hFFFF_C000) | 32'(d << 2) | 32'($urandom_range(0, 3)),
                 $urandom, 4'($urandom), 1'($urandom), 3'($urandom_range(0, 5)));
        sent++;
      end
    end
    chk("rand_sent", sent, 60);
    @(negedge clk);
    rsp_data_full_n = 1'b1;
    rsp_last_full_n = 1'b1;
    push_cmd(32'h0, 32'h0, 4'h0, 1'b0, 3'd7);
    wait_done("rand_done", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
